// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed spike-edge rate and last inter-spike interval, reported on a valid/ready port
module spike_rate_decoder #(
    parameter int WINDOW = 64,
    parameter int RATE_W = 8,
    parameter int ISI_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              spike_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [RATE_W-1:0] rate_out,
    output logic [ISI_W-1:0]  isi_out,
    output logic              overrun
);
    localparam int CW = $clog2(WINDOW);

    logic              spike_prev_q, spike_prev_d;
    logic [CW-1:0]     win_cnt_q, win_cnt_d;
    logic [RATE_W-1:0] spk_cnt_q, spk_cnt_d, spk_sum;
    logic [ISI_W-1:0]  isi_cnt_q, isi_cnt_d;
    logic [ISI_W-1:0]  isi_last_q, isi_last_d;
    logic              have_edge_q, have_edge_d;
    logic              out_valid_q, out_valid_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [ISI_W-1:0]  isi_q, isi_d;
    logic              overrun_q, overrun_d;
    logic              spk_edge, win_last, load;

    // Edge detect, window/spike/ISI counting and the result register with its drop-on-busy rule
    always_comb begin
        spk_edge     = spike_in & ~spike_prev_q & ena;
        win_last     = ena && (win_cnt_q == CW'(WINDOW - 1));
        spike_prev_d = spike_in;
        win_cnt_d    = win_last ? '0 : ena ? win_cnt_q + CW'(1) : win_cnt_q;
        spk_sum      = (spk_edge && spk_cnt_q != '1) ? spk_cnt_q + RATE_W'(1) : spk_cnt_q;
        spk_cnt_d    = win_last ? '0 : spk_sum;
        isi_last_d   = (spk_edge && have_edge_q) ? isi_cnt_q : isi_last_q;
        isi_cnt_d    = spk_edge ? ISI_W'(1) : (ena && isi_cnt_q != '1) ? isi_cnt_q + ISI_W'(1) : isi_cnt_q;
        have_edge_d  = have_edge_q | spk_edge;
        load         = win_last && (!out_valid_q || out_ready);
        out_valid_d  = load | (out_valid_q & ~out_ready);
        rate_d       = load ? spk_sum : rate_q;
        isi_d        = load ? isi_last_d : isi_q;
        overrun_d    = overrun_q | (win_last & out_valid_q & ~out_ready);
    end

    // State registers; rst_n is an asynchronous active-high clear
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            spike_prev_q <= 1'b0;
            win_cnt_q    <= '0;
            spk_cnt_q    <= '0;
            isi_cnt_q    <= '0;
            isi_last_q   <= '0;
            have_edge_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            rate_q       <= '0;
            isi_q        <= '0;
            overrun_q    <= 1'b0;
        end else begin
            spike_prev_q <= spike_prev_d;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            isi_cnt_q    <= isi_cnt_d;
            isi_last_q   <= isi_last_d;
            have_edge_q  <= have_edge_d;
            out_valid_q  <= out_valid_d;
            rate_q       <= rate_d;
            isi_q        <= isi_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rate_out  = rate_q;
    assign isi_out   = isi_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: event-time reference model plus directed and random stimulus
module tb_spike_rate_decoder;
    localparam int WINDOW = 16;
    localparam int RATE_W = 3;
    localparam int ISI_W  = 6;
    localparam int RMAX   = 7;
    localparam int IMAX   = 63;

    logic              clk = 0, rst_n = 0, ena = 0, spike_in = 0, out_ready = 0;
    logic              out_valid;
    logic [RATE_W-1:0] rate_out;
    logic [ISI_W-1:0]  isi_out;
    logic              overrun;

    int total = 0, bad = 0;

    int m_e = 0, m_win_edges = 0, m_prev_t = 0, m_isi_last = 0, m_rate = 0, m_isi = 0;
    bit m_have = 0, m_prev_spk = 0, m_valid = 0, m_ovr = 0, m_edge, m_close;

    spike_rate_decoder #(.WINDOW(WINDOW), .RATE_W(RATE_W), .ISI_W(ISI_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .out_ready(out_ready),
        .out_valid(out_valid), .rate_out(rate_out), .isi_out(isi_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return a < b ? a : b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_e is the number of enabled cycles since reset, edges are timestamped in it
    initial forever begin
        @(posedge clk or posedge rst_n);
        if (rst_n) begin
            m_e = 0; m_win_edges = 0; m_prev_t = 0; m_isi_last = 0; m_rate = 0; m_isi = 0;
            m_have = 0; m_prev_spk = 0; m_valid = 0; m_ovr = 0;
        end else begin
            m_edge  = spike_in && !m_prev_spk && ena;
            m_close = ena && (m_e % WINDOW == WINDOW - 1);
            if (m_edge) begin
                if (m_have) m_isi_last = imin(m_e - m_prev_t, IMAX);
                m_have = 1;
                m_prev_t = m_e;
                m_win_edges++;
            end
            if (m_close) begin
                if (!m_valid || out_ready) begin
                    m_rate  = imin(m_win_edges, RMAX);
                    m_isi   = m_isi_last;
                    m_valid = 1;
                end else m_ovr = 1;
                m_win_edges = 0;
            end else if (m_valid && out_ready) m_valid = 0;
            if (ena) m_e++;
            m_prev_spk = spike_in;
        end
    end

    // Every-cycle comparison against the model, half a cycle away from the active edge
    initial forever begin
        @(negedge clk);
        check("valid", out_valid, m_valid);
        check("overrun", overrun, m_ovr);
        check("rate", rate_out, m_rate);
        check("isi", isi_out, m_isi);
    end

    task automatic step(input bit e, input bit s, input bit r);
        ena = e; spike_in = s; out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_rate", rate_out, 0);
        check("rst_isi", isi_out, 0);
        check("rst_overrun", overrun, 0);
        ena = 0; spike_in = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 0;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1, i % 4 == 0, 1);
            if (i == 15 || i == 31) begin
                check("a_valid", out_valid, 1);
                check("a_rate", rate_out, 4);
                check("a_isi", isi_out, 4);
            end
            if (i == 16) check("a_drop", out_valid, 0);
        end

        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1, i >= 2 && i < 12, 1);
            if (i == 15) begin
                check("held_rate", rate_out, 1);
                check("held_isi", isi_out, 0);
            end
            if (i == 31) begin
                check("quiet_rate", rate_out, 0);
                check("quiet_isi", isi_out, 0);
            end
        end

        do_reset();
        for (int i = 0; i < 48; i++) begin
            step(1, i % 16 == 1 || i % 16 == 6, 0);
            if (i == 15) check("bp_ovr0", overrun, 0);
            if (i == 31) check("bp_ovr1", overrun, 1);
            if (i == 15 || i == 31 || i == 47) begin
                check("bp_valid", out_valid, 1);
                check("bp_rate", rate_out, 2);
                check("bp_isi", isi_out, 5);
            end
        end
        step(1, 0, 1);
        check("bp_drop", out_valid, 0);
        check("bp_ovr_sticky", overrun, 1);

        do_reset();
        for (int i = 0; i < 16; i++) step(1, i % 2 == 0, 1);
        check("sat_rate", rate_out, RMAX);
        check("sat_isi2", isi_out, 2);
        for (int j = 0; j < 96; j++) step(1, j == 82, 1);
        check("gap_rate", rate_out, 1);
        check("gap_isi", isi_out, IMAX);

        do_reset();
        for (int n = 0; n < 21; n++) begin
            step(!(n >= 5 && n < 10), n == 2 || n == 6 || n == 7, n < 20);
            if (n == 19) check("ena_early", out_valid, 0);
            if (n == 20) begin
                check("ena_close", out_valid, 1);
                check("ena_rate", rate_out, 1);
            end
        end
        for (int i = 0; i < 7; i++) step(1, i == 1 || i == 4, 0);
        check("pre_rst_valid", out_valid, 1);
        do_reset();
        for (int i = 0; i < 16; i++) step(1, i == 3 || i == 5 || i == 9, 1);
        check("post_rst_rate", rate_out, 3);
        check("post_rst_isi", isi_out, 4);
        check("post_rst_ovr", overrun, 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Converts a binary spike train, such as the output of the LIF neuron stage, back into numeric values. It counts spike rising edges over a fixed window of enabled cycles and tracks the most recent inter-spike interval (ISI). At each window close it presents both results on a valid/ready output port. It sits downstream of the neuron array, feeding readout logic or the next layer's synaptic-current generator.

## Interface
- WINDOW, 64: window length in ena-qualified cycles; legal range 2..65535.
- RATE_W, 8: width of rate_out; the count saturates at 2^RATE_W-1.
- ISI_W, 8: width of isi_out; the interval saturates at 2^ISI_W-1.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-high (despite the name).
- ena  in  1  count enable; while low, the window, spike and ISI counters freeze.
- spike_in  in  1  spike train; a pulse may be held high for multiple cycles.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  rate_out and isi_out hold an unconsumed result.
- rate_out  out  RATE_W  spike edges counted in the closed window, saturated.
- isi_out  out  ISI_W  last captured ISI at window close; 0 if none has been captured since reset.
- overrun  out  1  sticky flag: a window result was dropped.

## Operation
- Edge detect: spike_prev <= spike_in every cycle, independent of ena. edge = spike_in & ~spike_prev & ena.
  - A spike held high for N cycles counts once.
  - A spike rising while ena=0 is never counted.
- Window counter win_cnt runs 0..WINDOW-1 and advances only when ena=1.
  - The last cycle is the one with win_cnt==WINDOW-1 and ena=1; win_cnt wraps to 0 on that cycle.
- Spike counter: on edge, spk_cnt <= sat(spk_cnt+1).
  - On the last cycle, spk_cnt <= 0, and the closing value includes that cycle's edge.
  - An edge on the first cycle of the next window belongs to the next window.
- ISI tracking runs continuously and is not reset at window boundaries.
  - isi_cnt increments, saturating, on each ena cycle.
  - On edge: isi_last <= isi_cnt if have_edge, then isi_cnt <= 1 and have_edge <= 1.
  - Example: edges at enabled cycles t and t+3 give an ISI of 3.
  - If edge coincides with the last cycle, the new isi_last is the value reported.
- Output register, on the last cycle:
  - If !out_valid, or out_valid & out_ready: load rate_out and isi_out, and keep or set out_valid=1.
  - Else (result still pending): discard the new result, keep the old one, and set overrun=1.
- Handshake: transfer occurs when out_valid & out_ready. After a transfer with no simultaneous load, out_valid drops.
  - While valid and not ready, rate_out and isi_out are stable.
- overrun clears only on reset.
- Reset, including mid-window: all counters, have_edge, spike_prev, isi_last, out_valid, rate_out, isi_out and overrun go to 0 asynchronously. The first window after reset starts at win_cnt=0.

## Timing
- Output latency: out_valid, rate_out and isi_out are registered. They update on the clock edge that ends the last window cycle and are visible the following cycle.
- Handshake: out_ready is combinationally sampled; there is no combinational path from out_ready to out_valid.
- Back-to-back: out_ready may stay high permanently; each window then produces exactly one transfer.
- ena=0 during the last cycle defers the window close until the next ena=1 cycle.
- Arithmetic: all counters are unsigned. Saturation is a compare with the all-ones value, with no wrap.
- win_cnt width is $clog2(WINDOW).

## Test plan
- WINDOW=16, ena=1, out_ready=1, single-cycle spikes at window cycles 0,4,8,12 -> out_valid for 1 cycle after cycle 15, rate_out=4, isi_out=4; the next window also reports 4/4.
- spike_in held high for 10 cycles within one window -> rate_out=1. A second window with no spikes -> rate_out=0, isi_out=0.
- WINDOW=16, out_ready=0 for 3 windows, 2 spikes per window -> first result held stable, overrun=1 after the second close. out_ready=1 -> first result transfers, out_valid drops.
- WINDOW=600, spike toggling every cycle (300 edges) -> rate_out=255. Spike gap of 400 cycles -> isi_out=255.
- ena low for 5 cycles mid-window, with a spike rising during that time -> the spike is not counted and the window close is delayed by exactly 5 cycles.
- rst_n asserted at window cycle 7 with spk_cnt=2 -> all outputs 0 immediately. The next window counts from 0 and overrun stays 0.
